// File: rtl/bist_controller_if.sv
// ---------------------------------------------------------------------------
// bist_controller_if
//   Groups the BIST sequencing signals between the controller and the test
//   datapath / external pins.
//
//   bist_start  : start request (only its rising edge matters)
//   misr_sig    : current MISR signature
//   lfsr_init   : load LFSR seed
//   lfsr_en     : advance LFSR
//   misr_init   : clear MISR to its seed
//   misr_en     : MISR compacts CUT response
//   test_mode   : CUT input mux selects LFSR
//   bist_end    : test complete, pass_nfail valid (level)
//   pass_nfail  : 1 = signature matched
//
//   slave  : the controller side
//   master : the environment side (pins + datapath)
// ---------------------------------------------------------------------------
interface bist_controller_if #(
    parameter int SIG_WIDTH = 16
);
    logic                 bist_start;
    logic [SIG_WIDTH-1:0] misr_sig;
    logic                 lfsr_init;
    logic                 lfsr_en;
    logic                 misr_init;
    logic                 misr_en;
    logic                 test_mode;
    logic                 bist_end;
    logic                 pass_nfail;

    modport master (
        output bist_start, misr_sig,
        input  lfsr_init, lfsr_en, misr_init, misr_en, test_mode,
               bist_end, pass_nfail
    );

    modport slave (
        input  bist_start, misr_sig,
        output lfsr_init, lfsr_en, misr_init, misr_en, test_mode,
               bist_end, pass_nfail
    );
endinterface

// File: rtl/bist_controller.sv
// ---------------------------------------------------------------------------
// bist_controller
//   Sequencing FSM of the built-in self-test. On a rising edge of bist_start
//   it initialises LFSR and MISR, runs N_PATTERNS pattern cycles, flushes the
//   CUT pipeline for FLUSH_CYC cycles, compares the MISR signature against
//   GOLDEN_SIG and then reports bist_end / pass_nfail until the next start.
//
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : bist_controller_if.slave (start/signature in, control/status out)
//
//   All outputs are flops whose next value is decoded from the next state,
//   so every output lines up exactly with the state it belongs to.
// ---------------------------------------------------------------------------
module bist_controller #(
    parameter int                   N_PATTERNS = 2000,
    parameter int                   FLUSH_CYC  = 1,
    parameter int                   SIG_WIDTH  = 16,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
) (
    input  logic               clk,
    input  logic               reset,
    bist_controller_if.slave   bus
);

    localparam int PW = $clog2(N_PATTERNS);
    // FLUSH_CYC = 1 would give a zero-width counter; keep at least one bit
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [PW-1:0] PAT_LAST   = PW'(N_PATTERNS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          start_q;
    logic [PW-1:0] pat_cnt_q, pat_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          result_q, result_d;
    logic          start_evt;

    logic lfsr_init_q, lfsr_init_d;
    logic lfsr_en_q, lfsr_en_d;
    logic misr_init_q, misr_init_d;
    logic misr_en_q, misr_en_d;
    logic test_mode_q, test_mode_d;
    logic bist_end_q, bist_end_d;
    logic pass_nfail_q, pass_nfail_d;

    always_comb begin
        state_d     = state_q;
        pat_cnt_d   = pat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        result_d    = result_q;
        start_evt   = bus.bist_start & ~start_q;

        case (state_q)
            S_IDLE: begin
                if (start_evt) state_d = S_INIT;
            end
            S_INIT: begin
                pat_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // counter holds on the last pattern rather than wrapping
                if (pat_cnt_q == PAT_LAST) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    pat_cnt_d = pat_cnt_q + PW'(1);
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) state_d = S_COMPARE;
                else                           flush_cnt_d = flush_cnt_q + FW'(1);
            end
            S_COMPARE: begin
                // misr_sig has seen all N+F captures by this edge
                result_d = (bus.misr_sig == GOLDEN_SIG);
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (start_evt) begin
                    state_d  = S_INIT;
                    result_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        lfsr_init_d  = (state_d == S_INIT);
        misr_init_d  = (state_d == S_INIT);
        lfsr_en_d    = (state_d == S_RUN);
        misr_en_d    = (state_d == S_RUN) || (state_d == S_FLUSH);
        test_mode_d  = (state_d == S_INIT) || (state_d == S_RUN) ||
                       (state_d == S_FLUSH) || (state_d == S_COMPARE);
        bist_end_d   = (state_d == S_DONE);
        pass_nfail_d = (state_d == S_DONE) && result_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            pat_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            result_q     <= 1'b0;
            lfsr_init_q  <= 1'b0;
            lfsr_en_q    <= 1'b0;
            misr_init_q  <= 1'b0;
            misr_en_q    <= 1'b0;
            test_mode_q  <= 1'b0;
            bist_end_q   <= 1'b0;
            pass_nfail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.bist_start;
            pat_cnt_q    <= pat_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            result_q     <= result_d;
            lfsr_init_q  <= lfsr_init_d;
            lfsr_en_q    <= lfsr_en_d;
            misr_init_q  <= misr_init_d;
            misr_en_q    <= misr_en_d;
            test_mode_q  <= test_mode_d;
            bist_end_q   <= bist_end_d;
            pass_nfail_q <= pass_nfail_d;
        end
    end

    assign bus.lfsr_init  = lfsr_init_q;
    assign bus.lfsr_en    = lfsr_en_q;
    assign bus.misr_init  = misr_init_q;
    assign bus.misr_en    = misr_en_q;
    assign bus.test_mode  = test_mode_q;
    assign bus.bist_end   = bist_end_q;
    assign bus.pass_nfail = pass_nfail_q;

endmodule

// File: tb/tb_bist_controller.sv
// ---------------------------------------------------------------------------
// tb_bist_controller
//   Directed bench for bist_controller with N_PATTERNS=8, FLUSH_CYC=1,
//   GOLDEN_SIG=16'hA5C3. Outputs are sampled 1 time unit after each rising
//   edge and compared as a packed vector
//   {lfsr_init, lfsr_en, misr_init, misr_en, test_mode, bist_end, pass_nfail}.
//   Tick c after the edge that samples the start: c=1 INIT, c=2..9 RUN,
//   c=10 FLUSH, c=11 COMPARE, c=12 DONE.
// ---------------------------------------------------------------------------
module tb_bist_controller;

    localparam logic [15:0] GOLD = 16'hA5C3;

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_INIT  = 7'b1010100;
    localparam logic [6:0] O_RUN   = 7'b0101100;
    localparam logic [6:0] O_FLUSH = 7'b0001100;
    localparam logic [6:0] O_CMP   = 7'b0000100;
    localparam logic [6:0] O_DONEP = 7'b0000011;
    localparam logic [6:0] O_DONEF = 7'b0000010;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bist_controller_if #(.SIG_WIDTH(16)) bus ();

    bist_controller #(
        .N_PATTERNS (8),
        .FLUSH_CYC  (1),
        .SIG_WIDTH  (16),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] outs;
    assign outs = {bus.lfsr_init, bus.lfsr_en, bus.misr_init, bus.misr_en,
                   bus.test_mode, bus.bist_end, bus.pass_nfail};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [6:0] obs,
                       input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s c=%0d: outputs got %b expected %b", tag, c, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_vec(input int c, input bit pass);
        if (c == 1)       return O_INIT;
        else if (c <= 9)  return O_RUN;
        else if (c == 10) return O_FLUSH;
        else if (c == 11) return O_CMP;
        else              return pass ? O_DONEP : O_DONEF;
    endfunction

    // Caller guarantees bist_start was 0 at the previous edge. pulse_at>0
    // drives a second one-cycle pulse after tick pulse_at; hold keeps
    // bist_start high for the whole sequence. The wrong signature is shown
    // until COMPARE so the sampling point is exercised.
    task automatic run_seq(input string tag, input logic [15:0] sig,
                           input bit exp_pass, input int pulse_at,
                           input bit hold);
        bus.bist_start = 1'b1;
        bus.misr_sig   = ~sig;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk(tag, c, outs, exp_vec(c, exp_pass));
            bus.bist_start = hold || (c == pulse_at);
            if (c == 11) bus.misr_sig = sig;
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.bist_start = 1'b0;
        bus.misr_sig   = 16'h0000;

        // Reset: asynchronous assertion, start toggling while held
        #2 reset = 1'b0;
        #1 chk("reset_async", 0, outs, O_IDLE);
        for (int i = 0; i < 3; i++) begin
            bus.bist_start = ~bus.bist_start;
            tick();
            chk("reset_hold", i, outs, O_IDLE);
        end
        bus.bist_start = 1'b0;
        reset          = 1'b1;
        tick();
        chk("reset_release", 0, outs, O_IDLE);
        tick();
        chk("idle_quiet", 0, outs, O_IDLE);

        // Pass, then bist_end/pass_nfail hold as a level
        run_seq("pass", GOLD, 1'b1, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.misr_sig = 16'h0000;
            tick();
            chk("pass_hold", i, outs, O_DONEP);
        end

        // Fail: one bit off, restarted from DONE
        run_seq("fail", 16'hA5C2, 1'b0, 0, 1'b0);
        tick();
        chk("fail_hold", 0, outs, O_DONEF);

        // Ignored start pulse in RUN cycle 4
        run_seq("ign_start", GOLD, 1'b1, 5, 1'b0);
        tick();
        chk("ign_hold", 0, outs, O_DONEP);

        // Held start: run with bist_start high throughout, no retrigger
        run_seq("held_run", 16'h1234, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_done", i, outs, O_DONEF);
        end
        // Drop and raise again: bist_end/pass_nfail fall at the INIT edge
        bus.bist_start = 1'b0;
        tick();
        chk("held_drop", 0, outs, O_DONEF);
        run_seq("restart", GOLD, 1'b1, 0, 1'b0);

        // Abort in RUN cycle 5
        bus.bist_start = 1'b1;
        bus.misr_sig   = GOLD;
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.bist_start = 1'b0;
            chk("abort_pre", c, outs, exp_vec(c, 1'b1));
        end
        #2 reset = 1'b0;
        #1 chk("abort_async", 0, outs, O_IDLE);
        tick();
        chk("abort_hold", 0, outs, O_IDLE);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_idle", i, outs, O_IDLE);
        end

        // Recovery after abort
        run_seq("recover", GOLD, 1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencing FSM of the built-in self-test inside `top_level`. It sits directly between the external `bist_start`/`bist_end`/`pass_nfail` pins and the test datapath (pattern LFSR, CUT input mux, response MISR).
- On a start request it initialises the LFSR and MISR, then runs a fixed number of pattern cycles and flushes the CUT pipeline.
- It then compares the MISR signature with a golden value and reports completion and pass/fail until the next request.

## Interface
- `N_PATTERNS`, default 2000: number of pattern cycles in RUN; legal values ≥ 2.
- `FLUSH_CYC`, default 1: number of extra MISR-capture cycles after the last pattern, matching CUT latency; legal values ≥ 1.
- `SIG_WIDTH`, default 16: width of the MISR signature.
- `GOLDEN_SIG`, default 16'h0000: expected fault-free signature; set per build.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `bist_start` input 1: start request; only its rising edge, as sampled by `clk`, matters.
- `misr_sig` input `SIG_WIDTH`: current MISR contents.
- `lfsr_init` output 1: load the LFSR seed.
- `lfsr_en` output 1: advance the LFSR.
- `misr_init` output 1: clear the MISR to its seed.
- `misr_en` output 1: MISR compacts the CUT response.
- `test_mode` output 1: CUT input mux selects the LFSR instead of functional inputs.
- `bist_end` output 1: test complete; `pass_nfail` is valid.
- `pass_nfail` output 1: 1 = signature matched, 0 = fail or no result.

## Operation
- **Edge detector.** Register `start_q` holds the previous sample of `bist_start`. `start_evt = bist_start & ~start_q`.
- **Pattern counter.** Width `$clog2(N_PATTERNS)`. It is cleared in INIT and increments every RUN cycle. No wrap occurs: RUN exits when the count reaches `N_PATTERNS-1`.
- **Flush counter.** It is cleared on entry to FLUSH and counts to `FLUSH_CYC-1`.
- **States and transitions.**
  - IDLE → INIT on `start_evt`.
  - INIT → RUN unconditionally (1 cycle).
  - RUN → FLUSH when the pattern count equals `N_PATTERNS-1`.
  - FLUSH → COMPARE when the flush count equals `FLUSH_CYC-1`.
  - COMPARE → DONE unconditionally (1 cycle).
  - DONE → INIT on `start_evt`; otherwise DONE holds.
- **Outputs per state.** All outputs are registered; next-state logic decodes them.
  - IDLE: all outputs 0.
  - INIT: `lfsr_init`=1, `misr_init`=1, `test_mode`=1.
  - RUN: `lfsr_en`=1, `misr_en`=1, `test_mode`=1.
  - FLUSH: `misr_en`=1, `test_mode`=1, `lfsr_en`=0.
  - COMPARE: `test_mode`=1. The result register loads `(misr_sig == GOLDEN_SIG)`.
  - DONE: `bist_end`=1, `pass_nfail`=result, `test_mode`=0.
- **`pass_nfail`.**
  - It is 0 outside DONE.
  - It is cleared when DONE exits to INIT.
- **Ignored starts.** A `start_evt` in INIT, RUN, FLUSH or COMPARE is ignored. It is neither queued nor able to restart the sequence.
- **Held start.** A `bist_start` held high through the whole run does not retrigger in DONE; it must fall and rise again.
- **Comparison.** Full-width equality on `misr_sig`; there is no masking.

## Timing
- **Reset values.** Asserting `reset` low drives all of the following immediately, independent of `clk`:
  - state = IDLE;
  - `start_q`=0 and both counters = 0;
  - every output = 0.
- **Reset mid-operation.** It aborts the run. No `bist_end` pulse or stale result appears afterwards.
- **Reset release.** Synchronous in effect. The first rising edge with `reset`=1 may already sample `start_evt`.
- **Latency.** Let edge k be the edge that samples `start_evt`.
  - k: state ← INIT.
  - k+1: state ← RUN.
  - k+1+N: state ← FLUSH.
  - k+1+N+F: state ← COMPARE.
  - k+2+N+F: state ← DONE, `bist_end`↑.
  - Total start-to-end: N+F+2 cycles after edge k.
- **RUN length.** `lfsr_en` is high for exactly N consecutive cycles.
- **`misr_en` length.** High for exactly N+F consecutive cycles.
- **Signature sampling.** `misr_sig` is sampled at the COMPARE-exit edge and reflects all N+F captures.
- **`bist_end`.** Level, not pulse. It stays high until the next accepted start or reset, then falls at the edge entering INIT.

## Test plan
Bench setup for all scenarios: N_PATTERNS=8, FLUSH_CYC=1, SIG_WIDTH=16, GOLDEN_SIG=16'hA5C3. `misr_sig` is driven by the bench.

- **Reset.** Hold `reset`=0 for 3 cycles with `bist_start` toggling → all outputs 0; the state stays IDLE throughout.
- **Pass.** Pulse `bist_start` for one cycle; drive `misr_sig`=16'hA5C3 during COMPARE →
  - INIT visible 1 cycle after the start edge;
  - `lfsr_en` high 8 cycles and `misr_en` high 9 cycles;
  - `bist_end`=1 and `pass_nfail`=1 exactly 11 cycles after the sampling edge, holding for 20 further cycles.
- **Fail.** Same as Pass but `misr_sig`=16'hA5C2 → `bist_end`=1 at cycle 11 with `pass_nfail`=0.
- **Ignored start.** Give a second `bist_start` pulse in RUN cycle 4 → no restart; `bist_end` still arrives at cycle 11.
- **Restart.**
  - From DONE with `bist_start` held high → no restart.
  - Then drop `bist_start` and raise it again → `bist_end` and `pass_nfail` fall at the INIT edge, and the new result appears 11 cycles later.
- **Abort.** Assert `reset` low in RUN cycle 5 → all outputs 0 immediately. After release with no start, `bist_end` stays 0 for 20 cycles.
